// File: rtl/vdu_char_pixel_if.sv
// Signal bundle between the VDU timing generator, video RAM, font ROM and the
// character pixel generator.
interface vdu_char_pixel_if;
  logic        char_stb;
  logic [12:0] video_address;
  logic [4:0]  row_in;
  logic        de_in;
  logic        hs_in;
  logic        vs_in;
  logic [12:0] ram_addr;
  logic        ram_rd;
  logic [7:0]  ram_data;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic [12:0] cursor_addr;
  logic        cursor_en;
  logic        pixel;
  logic        de_out;
  logic        hs_out;
  logic        vs_out;

  modport master (
    output char_stb, video_address, row_in, de_in, hs_in, vs_in,
           ram_data, font_data, cursor_addr, cursor_en,
    input  ram_addr, ram_rd, font_addr, pixel, de_out, hs_out, vs_out
  );

  modport slave (
    input  char_stb, video_address, row_in, de_in, hs_in, vs_in,
           ram_data, font_data, cursor_addr, cursor_en,
    output ram_addr, ram_rd, font_addr, pixel, de_out, hs_out, vs_out
  );
endinterface

// File: rtl/vdu_char_pixel.sv
// Text-mode pixel generator: RAM read, font lookup, MSB-first serialiser with
// inverse video and blinking cursor, plus a matching 4-stage de/hs/vs delay.
module vdu_char_pixel #(
  parameter int unsigned CHAR_W       = 8,
  parameter int unsigned CUR_START    = 13,
  parameter int unsigned CUR_END      = 14,
  parameter int unsigned BLINK_FRAMES = 16
) (
  input logic             clk,
  input logic             resetn,
  vdu_char_pixel_if.slave bus
);

  // Cells wider than the 8-pixel glyph simply run out into zero columns.
  localparam int unsigned SHW        = (CHAR_W > 8) ? CHAR_W : 8;
  localparam int unsigned BCW        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_FRAMES - 1);
  localparam logic [4:0]     CUR_LO     = 5'(CUR_START);
  localparam logic [4:0]     CUR_HI     = 5'(CUR_END);

  logic [3:0]     de_dly, hs_dly, vs_dly;
  logic           vs_prev;
  logic [BCW-1:0] blink_cnt;
  logic           blink_on;

  logic           s1_vld, s1_blank, s1_cur;
  logic [3:0]     s1_row;
  logic [12:0]    ram_addr_q;
  logic           s2_vld, s2_blank, s2_cur, s2_inv;
  logic [10:0]    font_addr_q;
  logic [SHW-1:0] shifter;
  logic           mask;
  logic           pixel_q;
  logic           cur_hit;

  always_comb begin
    cur_hit = bus.cursor_en & blink_on
            & (bus.video_address == bus.cursor_addr)
            & (bus.row_in >= CUR_LO) & (bus.row_in <= CUR_HI);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      de_dly    <= '0;
      hs_dly    <= '0;
      vs_dly    <= '0;
      vs_prev   <= 1'b0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else begin
      de_dly  <= {de_dly[2:0], bus.de_in};
      hs_dly  <= {hs_dly[2:0], bus.hs_in};
      vs_dly  <= {vs_dly[2:0], bus.vs_in};
      vs_prev <= bus.vs_in;
      if (bus.vs_in && !vs_prev) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + BCW'(1);
        end
      end
    end
  end

  // Three independent stages, each carrying its own tags, so a new strobe
  // every CHAR_W cycles streams without gaps.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_vld      <= 1'b0;
      s1_blank    <= 1'b0;
      s1_cur      <= 1'b0;
      s1_row      <= '0;
      ram_addr_q  <= '0;
      s2_vld      <= 1'b0;
      s2_blank    <= 1'b0;
      s2_cur      <= 1'b0;
      s2_inv      <= 1'b0;
      font_addr_q <= '0;
      shifter     <= '0;
      mask        <= 1'b0;
      pixel_q     <= 1'b0;
    end else begin
      s1_vld <= bus.char_stb;
      if (bus.char_stb) begin
        ram_addr_q <= bus.video_address;
        s1_blank   <= ~bus.de_in | bus.row_in[4];
        s1_cur     <= cur_hit;
        s1_row     <= bus.row_in[3:0];
      end

      s2_vld <= s1_vld;
      if (s1_vld) begin
        font_addr_q <= {bus.ram_data[6:0], s1_row};
        s2_inv      <= bus.ram_data[7];
        s2_blank    <= s1_blank;
        s2_cur      <= s1_cur;
      end

      if (s2_vld) begin
        shifter <= s2_blank ? '0 : (SHW'(bus.font_data) << (SHW - 8));
        mask    <= (s2_inv ^ s2_cur) & ~s2_blank;
      end else begin
        shifter <= shifter << 1;
      end

      // de_dly[2] is the de value that reaches de_out alongside this pixel.
      pixel_q <= (shifter[SHW-1] ^ mask) & de_dly[2];
    end
  end

  always_comb begin
    bus.ram_addr  = ram_addr_q;
    bus.ram_rd    = s1_vld;
    bus.font_addr = font_addr_q;
    bus.pixel     = pixel_q;
    bus.de_out    = de_dly[3];
    bus.hs_out    = hs_dly[3];
    bus.vs_out    = vs_dly[3];
  end

endmodule

// File: tb/tb_vdu_char_pixel.sv
// Randomised scoreboard bench for vdu_char_pixel: a history-based reference
// model predicts every output cycle; a monitor compares on the falling edge.
module tb_vdu_char_pixel;

  localparam int unsigned BF   = 2;
  localparam int unsigned CS   = 13;
  localparam int unsigned CE   = 14;
  localparam int          MAXE = 4096;

  typedef struct {
    bit         rst;
    bit         stb;
    logic [12:0] addr;
    bit         de;
    bit         hs;
    bit         vs;
    bit  [7:0]  glyph;
    bit         mask;
    logic [10:0] fa;
  } edge_rec_t;

  typedef struct {
    int          n;
    bit          pixel;
    bit          de;
    bit          hs;
    bit          vs;
    bit          rd;
    bit          chk_addr;
    logic [12:0] ram_addr;
    bit          chk_fa;
    logic [10:0] fa;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  vdu_char_pixel_if vif();

  vdu_char_pixel #(
    .CHAR_W(8),
    .CUR_START(CS),
    .CUR_END(CE),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(vif)
  );

  always #5 clk = ~clk;

  logic [7:0] ram_mem  [0:8191];
  logic [7:0] font_mem [0:2047];
  assign vif.ram_data  = ram_mem[vif.ram_addr];
  assign vif.font_data = font_mem[vif.font_addr];

  edge_rec_t hist [MAXE];
  exp_t      sb [$];
  int        n_edges  = 0;
  int        vs_rises = 0;
  bit        vs_last  = 1'b0;
  bit        vs_level = 1'b0;
  int        tests    = 0;
  int        fails    = 0;

  function automatic exp_t predict(input int n);
    exp_t e;
    bit   clean;
    int   k;
    bit   b;
    e = '{default: 0};
    e.n = n;
    clean = (n >= 3);
    for (int i = n - 3; i <= n; i++)
      if (i < 0 || !hist[i].rst) clean = 1'b0;
    if (clean) begin
      e.de = hist[n-3].de;
      e.hs = hist[n-3].hs;
      e.vs = hist[n-3].vs;
    end
    e.rd       = hist[n].rst && hist[n].stb;
    e.chk_addr = e.rd || !hist[n].rst;
    e.ram_addr = hist[n].rst ? hist[n].addr : 13'h0;
    if (!hist[n].rst) begin
      e.chk_fa = 1'b1;
      e.fa     = 11'h0;
    end else if (n >= 1 && hist[n-1].rst && hist[n-1].stb) begin
      e.chk_fa = 1'b1;
      e.fa     = hist[n-1].fa;
    end
    if (clean && e.de) begin
      for (int j = n - 3; j >= 0; j--) begin
        if (!hist[j].rst) break;
        if (hist[j].stb) begin
          k = n - 3 - j;
          b = (k < 8) ? hist[j].glyph[7-k] : 1'b0;
          e.pixel = b ^ hist[j].mask;
          break;
        end
      end
    end
    return e;
  endfunction

  task automatic drive(input bit rst, input bit stb, input logic [12:0] addr,
                       input logic [4:0] row, input bit de);
    edge_rec_t  r;
    bit         hs;
    bit         blank, blink, cur;
    logic [7:0] code;
    if (n_edges >= MAXE) begin
      $display("FAIL edge_budget: got %0d edges, limit %0d", n_edges, MAXE);
      $fatal(1);
    end
    hs = 1'($urandom_range(1, 0));
    resetn            = rst;
    vif.char_stb      = stb;
    vif.video_address = addr;
    vif.row_in        = row;
    vif.de_in         = de;
    vif.hs_in         = hs;
    vif.vs_in         = vs_level;
    blank = !de || row[4];
    blink = ((vs_rises / BF) % 2) == 0;
    cur   = vif.cursor_en && blink && (addr == vif.cursor_addr) && (row >= CS) && (row <= CE);
    code  = ram_mem[addr];
    r.rst   = rst;
    r.stb   = stb;
    r.addr  = addr;
    r.de    = de;
    r.hs    = hs;
    r.vs    = vs_level;
    r.fa    = {code[6:0], row[3:0]};
    r.glyph = blank ? 8'h00 : font_mem[r.fa];
    r.mask  = !blank && (code[7] ^ cur);
    if (!rst) begin
      vs_rises = 0;
      vs_last  = 1'b0;
    end else begin
      if (vs_level && !vs_last) vs_rises++;
      vs_last = vs_level;
    end
    hist[n_edges] = r;
    sb.push_back(predict(n_edges));
    n_edges++;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int cycles, input bit de);
    for (int i = 0; i < cycles; i++) drive(1'b1, 1'b0, 13'h0, 5'd0, de);
  endtask

  task automatic char_cell(input logic [12:0] addr, input logic [4:0] row,
                           input bit de, input int gap);
    drive(1'b1, 1'b1, addr, row, de);
    for (int i = 1; i < gap; i++) drive(1'b1, 1'b0, addr, row, de);
  endtask

  task automatic check(input string name, input int nidx,
                       input logic [15:0] act, input logic [15:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, nidx, act, expv);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pixel",  e.n, 16'(vif.pixel),  16'(e.pixel));
        check("de_out", e.n, 16'(vif.de_out), 16'(e.de));
        check("hs_out", e.n, 16'(vif.hs_out), 16'(e.hs));
        check("vs_out", e.n, 16'(vif.vs_out), 16'(e.vs));
        check("ram_rd", e.n, 16'(vif.ram_rd), 16'(e.rd));
        if (e.chk_addr) check("ram_addr",  e.n, 16'(vif.ram_addr),  16'(e.ram_addr));
        if (e.chk_fa)   check("font_addr", e.n, 16'(vif.font_addr), 16'(e.fa));
      end
    end
  end

  initial begin
    int          gap;
    logic [12:0] a;
    for (int i = 0; i < 8192; i++) ram_mem[i]  = 8'($urandom);
    for (int i = 0; i < 2048; i++) font_mem[i] = 8'($urandom);
    vif.cursor_addr = 13'h050;
    vif.cursor_en   = 1'b0;

    // Reset dominates a simultaneous strobe.
    repeat (4) drive(1'b0, 1'b1, 13'h0, 5'd3, 1'b1);

    ram_mem[0] = 8'h41;
    font_mem[11'h413] = 8'hA5;
    repeat (3) char_cell(13'h000, 5'd3, 1'b1, 8);

    ram_mem[0] = 8'hC1;
    repeat (2) char_cell(13'h000, 5'd3, 1'b1, 8);
    repeat (2) char_cell(13'h000, 5'd3, 1'b0, 8);
    idle(4, 1'b1);

    vif.cursor_en = 1'b1;
    ram_mem[13'h050] = 8'h20;
    font_mem[{7'h20, 4'd12}] = 8'h00;
    font_mem[{7'h20, 4'd13}] = 8'h00;
    font_mem[{7'h20, 4'd14}] = 8'h00;
    char_cell(13'h050, 5'd13, 1'b1, 8);
    char_cell(13'h050, 5'd12, 1'b1, 8);
    char_cell(13'h050, 5'd14, 1'b1, 8);
    char_cell(13'h050, 5'd15, 1'b1, 8);
    vif.cursor_en = 1'b0;
    char_cell(13'h050, 5'd13, 1'b1, 8);
    vif.cursor_en = 1'b1;

    // Blink: restart the frame count, then one cursor cell per frame.
    repeat (2) drive(1'b0, 1'b0, 13'h0, 5'd0, 1'b1);
    for (int f = 0; f < 5; f++) begin
      char_cell(13'h050, 5'd13, 1'b1, 8);
      if (f < 4) begin
        vs_level = 1'b1;
        idle(2, 1'b1);
        vs_level = 1'b0;
        idle(2, 1'b1);
      end
    end

    vif.cursor_en = 1'b0;
    ram_mem[13'h100] = 8'h12;
    ram_mem[13'h101] = 8'h13;
    font_mem[{7'h12, 4'd5}] = 8'hFF;
    font_mem[{7'h13, 4'd5}] = 8'h81;
    char_cell(13'h100, 5'd5, 1'b1, 8);
    char_cell(13'h101, 5'd5, 1'b1, 8);
    idle(4, 1'b1);
    char_cell(13'h100, 5'd5, 1'b1, 5);
    char_cell(13'h101, 5'd5, 1'b1, 8);
    idle(2, 1'b1);

    // Reset partway through a character, then idle with de high.
    drive(1'b1, 1'b1, 13'h100, 5'd5, 1'b1);
    idle(4, 1'b1);
    drive(1'b0, 1'b0, 13'h0, 5'd0, 1'b1);
    idle(12, 1'b1);
    char_cell(13'h101, 5'd5, 1'b1, 8);

    vif.cursor_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(5, 0) == 0) vs_level = ~vs_level;
      if ($urandom_range(99, 0) < 5) begin
        repeat ($urandom_range(2, 1)) drive(1'b0, 1'b0, 13'h0, 5'd0, 1'b1);
      end else begin
        gap = int'($urandom_range(12, 3));
        a   = ($urandom_range(1, 0) == 0) ? 13'h050 : 13'($urandom);
        char_cell(a, 5'($urandom_range(31, 0)), $urandom_range(9, 0) != 0, gap);
      end
    end
    idle(6, 1'b1);

    @(negedge clk);
    #1;
    check("scoreboard_drain", n_edges, 16'(sb.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
